magia_eu_obi_initiator: RTL and testbench

- OBI initiator (manager) that issues register reads and writes toward the tile Event Unit OBI target port.
- Takes a simple valid/ready command stream from a local agent, e.g. a remote event injector or a debug/test sequencer.
- Drives OBI A-channel requests with stable-until-grant semantics and tracks outstanding transactions.
- Returns in-order responses on a valid/ready response stream; it is the requester end of the protocol the Event Unit wrapper terminates.

---
 rtl/magia_eu_obi_initiator.sv | 205 ++++++++++++++++++++
 tb/tb_magia_eu_obi_initiator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/magia_eu_obi_initiator.sv
// OBI manager that issues register reads/writes toward the tile Event Unit target port.
// Commands arrive on a valid/ready stream; responses return in order from a credit-limited FIFO.
module magia_eu_obi_initiator_chk #(
   parameter int unsigned CNT_W           = 3,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [CNT_W-1:0] fcnt_i,
   input  logic             rvalid_i,
   input  logic [CNT_W-1:0] inflight_i
);
   // FIFO overflow and responses with nothing in flight are protocol errors
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(push_i && !pop_i && (fcnt_i == CNT_W'(MAX_OUTSTANDING))));
         assert (!(rvalid_i && (inflight_i == {CNT_W{1'b0}})));
      end
   end
endmodule

module magia_eu_obi_initiator #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter logic [31:0] EU_BASE_ADDR    = 32'h0000_0000,
   parameter logic [31:0] EU_SIZE         = 32'h0000_1000,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_W-1:0]     cmd_offset_i,
   input  logic [DATA_W-1:0]     cmd_wdata_i,
   input  logic [DATA_W/8-1:0]   cmd_be_i,
   output logic                  obi_req_o,
   output logic [ADDR_W-1:0]     obi_addr_o,
   output logic                  obi_we_o,
   output logic [DATA_W/8-1:0]   obi_be_o,
   output logic [DATA_W-1:0]     obi_wdata_o,
   input  logic                  obi_gnt_i,
   input  logic                  obi_rvalid_i,
   input  logic [DATA_W-1:0]     obi_rdata_i,
   input  logic                  obi_err_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
   localparam logic [PTR_W-1:0]  ONE_P    = PTR_W'(1);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(EU_BASE_ADDR);
   localparam logic [ADDR_W-1:0] SIZE     = ADDR_W'(EU_SIZE);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_LERR = 2'd2;

   logic [1:0]                 r_state;
   logic [1:0]                 w_state_nxt;
   logic [ADDR_W-1:0]          r_addr;
   logic                       r_we;
   logic [DATA_W/8-1:0]        r_be;
   logic [DATA_W-1:0]          r_wdata;
   logic [CNT_W-1:0]           r_credits;
   logic [CNT_W-1:0]           r_fcnt;
   logic [PTR_W-1:0]           r_wptr;
   logic [PTR_W-1:0]           r_rptr;
   logic [DATA_W-1:0]          r_fdata [MAX_OUTSTANDING];
   logic                       r_ferr  [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] r_weq;
   logic [MAX_OUTSTANDING-1:0] w_weq_shift;
   logic [MAX_OUTSTANDING-1:0] w_weq_nxt;
   logic [CNT_W-1:0]           w_inflight;
   logic [CNT_W-1:0]           w_wslot;
   logic w_req, w_grant, w_rvalid, w_lerr_push, w_push, w_pop, w_accept, w_in_range, w_inc;
   logic [DATA_W-1:0]          w_push_data;
   logic                       w_push_err;

   assign w_req       = (r_state == S_REQ) && (r_credits < MAX_CNT);
   assign w_grant     = w_req & obi_gnt_i;
   assign w_inflight  = r_credits - r_fcnt;
   // Responses with nothing in flight (e.g. stragglers from before a reset) are dropped
   assign w_rvalid    = obi_rvalid_i && (w_inflight != {CNT_W{1'b0}});
   assign w_lerr_push = (r_state == S_LERR) && (w_inflight == {CNT_W{1'b0}}) && (r_credits < MAX_CNT);
   assign w_push      = w_rvalid | w_lerr_push;
   assign w_pop       = (r_fcnt != {CNT_W{1'b0}}) & rsp_ready_i;
   assign w_inc       = w_grant | w_lerr_push;
   assign cmd_ready_o = !rst_i && ((r_state == S_IDLE) || w_grant);
   assign w_accept    = cmd_valid_i & cmd_ready_o;
   assign w_in_range  = cmd_offset_i < SIZE;
   assign w_push_data = (w_rvalid && !r_weq[0]) ? obi_rdata_i : {DATA_W{1'b0}};
   assign w_push_err  = w_rvalid ? obi_err_i : 1'b1;
   assign w_wslot     = w_inflight - CNT_W'(w_rvalid);
   assign w_weq_shift = w_rvalid ? (r_weq >> 1'b1) : r_weq;

   assign obi_req_o   = w_req;
   assign obi_addr_o  = r_addr;
   assign obi_we_o    = r_we;
   assign obi_be_o    = r_be;
   assign obi_wdata_o = r_wdata;
   assign rsp_valid_o = (r_fcnt != {CNT_W{1'b0}});
   assign rsp_rdata_o = rsp_valid_o ? r_fdata[r_rptr] : {DATA_W{1'b0}};
   assign rsp_err_o   = rsp_valid_o ? r_ferr[r_rptr] : 1'b0;
   assign busy_o      = (r_state != S_IDLE) | (r_credits != {CNT_W{1'b0}});

   // Next-state: a new accept wins; otherwise grant or local-error push returns to idle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_REQ: begin
            if (w_accept)     w_state_nxt = w_in_range ? S_REQ : S_LERR;
            else if (w_grant) w_state_nxt = S_IDLE;
            else              w_state_nxt = r_state;
         end
         S_LERR:  w_state_nxt = w_lerr_push ? S_IDLE : S_LERR;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Write-flag queue: head retires on rvalid, a granted request lands behind the survivors
   always_comb begin
      w_weq_nxt = w_weq_shift;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         w_weq_nxt[i] = (w_grant && (CNT_W'(i) == w_wslot)) ? r_we : w_weq_shift[i];
      end
   end

   // State, held command and credit counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_addr    <= {ADDR_W{1'b0}};
         r_we      <= 1'b0;
         r_be      <= {(DATA_W/8){1'b0}};
         r_wdata   <= {DATA_W{1'b0}};
         r_credits <= {CNT_W{1'b0}};
         r_weq     <= {MAX_OUTSTANDING{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_weq   <= w_weq_nxt;
         if (w_accept && w_in_range) begin
            r_addr  <= BASE + cmd_offset_i;
            r_we    <= cmd_we_i;
            r_be    <= cmd_we_i ? cmd_be_i : {(DATA_W/8){1'b0}};
            r_wdata <= cmd_we_i ? cmd_wdata_i : {DATA_W{1'b0}};
         end
         case ({w_inc, w_pop})
            2'b10:   r_credits <= r_credits + ONE_C;
            2'b01:   r_credits <= r_credits - ONE_C;
            default: r_credits <= r_credits;
         endcase
      end
   end

   // Response FIFO storing {rdata, err}
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr <= {PTR_W{1'b0}};
         r_rptr <= {PTR_W{1'b0}};
         r_fcnt <= {CNT_W{1'b0}};
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_fdata[i] <= {DATA_W{1'b0}};
            r_ferr[i]  <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_fdata[r_wptr] <= w_push_data;
            r_ferr[r_wptr]  <= w_push_err;
            r_wptr          <= (r_wptr == LAST_PTR) ? {PTR_W{1'b0}} : r_wptr + ONE_P;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LAST_PTR) ? {PTR_W{1'b0}} : r_rptr + ONE_P;
         end
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + ONE_C;
            2'b01:   r_fcnt <= r_fcnt - ONE_C;
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

`ifndef SYNTHESIS
   magia_eu_obi_initiator_chk #(
      .CNT_W           (CNT_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_chk (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (w_push),
      .pop_i      (w_pop),
      .fcnt_i     (r_fcnt),
      .rvalid_i   (obi_rvalid_i),
      .inflight_i (w_inflight)
   );
`endif
endmodule

// File: tb/tb_magia_eu_obi_initiator.sv
// Scoreboard bench for magia_eu_obi_initiator with a delay-configurable OBI target model.
module tb_magia_eu_obi_initiator;
   localparam logic [31:0] BASE = 32'h0010_0000;
   localparam logic [31:0] SIZE = 32'h0000_1000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_we = 1'b0;
   logic [31:0] cmd_offset = 32'h0, cmd_wdata = 32'h0;
   logic [3:0]  cmd_be = 4'h0;
   logic        gnt = 1'b0, rvalid = 1'b0, rerr = 1'b0, rdy = 1'b1;
   logic [31:0] rdata = 32'h0;
   logic        cmd_ready_o, obi_req_o, obi_we_o, rsp_valid_o, rsp_err_o, busy_o;
   logic [31:0] obi_addr_o, obi_wdata_o, rsp_rdata_o;
   logic [3:0]  obi_be_o;

   typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;
                    logic [31:0] rdata; logic err; int rvd; } bus_t;
   typedef struct { logic [31:0] rdata; logic err; int due; } pend_t;
   typedef struct { logic [31:0] rdata; logic err; } rsp_t;
   bus_t  exp_bus_q[$];
   pend_t pend_q[$];
   rsp_t  exp_q[$];

   int cyc = 0, n_chk = 0, n_pass = 0, n_gnt = 0, gnt_delay = 0, t_acc = 0;

   magia_eu_obi_initiator #(.ADDR_W(32), .DATA_W(32), .EU_BASE_ADDR(BASE), .EU_SIZE(SIZE),
                            .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
      .cmd_we_i(cmd_we), .cmd_offset_i(cmd_offset), .cmd_wdata_i(cmd_wdata), .cmd_be_i(cmd_be),
      .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
      .obi_wdata_o(obi_wdata_o), .obi_gnt_i(gnt), .obi_rvalid_i(rvalid), .obi_rdata_i(rdata),
      .obi_err_i(rerr), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rdy), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .busy_o(busy_o));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
   endtask

   // Drive one command; expectations are queued at the moment it is accepted
   task automatic send(input logic we, input logic [31:0] off, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] rd, input logic err, input int rvd);
      bus_t b;
      rsp_t r;
      bit   ok = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_we = we; cmd_offset = off; cmd_wdata = wd; cmd_be = be;
      for (int k = 0; k < 300 && !ok; k++) begin
         @(negedge clk); #1;
         if (cmd_ready_o) begin
            ok = 1'b1;
            t_acc = cyc;
            if (off < SIZE) begin
               b.addr = BASE + off; b.we = we; b.be = we ? be : 4'h0;
               b.wdata = we ? wd : 32'h0; b.rdata = rd; b.err = err; b.rvd = rvd;
               exp_bus_q.push_back(b);
               r.rdata = we ? 32'h0 : rd; r.err = err;
            end else begin
               r.rdata = 32'h0; r.err = 1'b1;
            end
            exp_q.push_back(r);
         end
      end
      if (!ok) check("cmd_accept", {63'h0, cmd_ready_o}, 64'h1);
   endtask

   task automatic cmd_idle();
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk); #1;
         done = (exp_q.size() == 0) && !busy_o && !cmd_valid;
      end
      check("drain_busy", {63'h0, busy_o}, 64'h0);
      check("drain_rsp_left", 64'(exp_q.size()), 64'h0);
      @(posedge clk); #1;
   endtask

   // OBI target model: grant after gnt_delay stalled cycles, respond rvd cycles after grant
   initial begin
      int          wcnt;
      bit          held;
      logic [31:0] haddr;
      pend_t       p;
      bus_t        b;
      wcnt = 0; held = 1'b0; haddr = 32'h0;
      forever begin
         @(negedge clk);
         if (pend_q.size() > 0 && cyc >= pend_q[0].due) begin
            p = pend_q.pop_front();
            rvalid = 1'b1; rdata = p.rdata; rerr = p.err;
         end else begin
            rvalid = 1'b0; rdata = 32'h0; rerr = 1'b0;
         end
         if (held) begin
            check("req_held", {63'h0, obi_req_o}, 64'h1);
            check("addr_stable", {32'h0, obi_addr_o}, {32'h0, haddr});
         end
         held = 1'b0;
         gnt  = 1'b0;
         if (obi_req_o) begin
            if (wcnt >= gnt_delay) begin
               gnt = 1'b1; wcnt = 0; n_gnt++;
               if (exp_bus_q.size() == 0) begin
                  check("bus_unexpected", {63'h0, obi_req_o}, 64'h0);
               end else begin
                  b = exp_bus_q.pop_front();
                  check("obi_addr", {32'h0, obi_addr_o}, {32'h0, b.addr});
                  check("obi_we", {63'h0, obi_we_o}, {63'h0, b.we});
                  check("obi_be", {60'h0, obi_be_o}, {60'h0, b.be});
                  check("obi_wdata", {32'h0, obi_wdata_o}, {32'h0, b.wdata});
                  p.rdata = b.rdata; p.err = b.err; p.due = cyc + 1 + b.rvd;
                  pend_q.push_back(p);
               end
            end else begin
               wcnt++; held = 1'b1; haddr = obi_addr_o;
            end
         end
      end
   end

   // Response consumer: pops the scoreboard on each handshake, checks stability while stalled
   initial begin
      rsp_t        e;
      bit          stall;
      logic [31:0] hd;
      logic        he;
      stall = 1'b0; hd = 32'h0; he = 1'b0;
      forever begin
         @(negedge clk);
         if (stall) begin
            check("rsp_hold_valid", {63'h0, rsp_valid_o}, 64'h1);
            check("rsp_hold_data", {32'h0, rsp_rdata_o}, {32'h0, hd});
            check("rsp_hold_err", {63'h0, rsp_err_o}, {63'h0, he});
         end
         stall = 1'b0;
         if (rsp_valid_o) begin
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  check("rsp_extra", {63'h0, rsp_valid_o}, 64'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("rsp_rdata", {32'h0, rsp_rdata_o}, {32'h0, e.rdata});
                  check("rsp_err", {63'h0, rsp_err_o}, {63'h0, e.err});
               end
            end else begin
               stall = 1'b1; hd = rsp_rdata_o; he = rsp_err_o;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ta, lat, nreq, base;
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h0);
      check("rst_req", {63'h0, obi_req_o}, 64'h0);
      check("rst_addr", {32'h0, obi_addr_o}, 64'h0);
      check("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
      check("rst_busy", {63'h0, busy_o}, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("idle_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);

      // Single zero-wait write: response three cycles after acceptance
      send(1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, 0);
      ta = t_acc;
      cmd_idle();
      seen = 1'b0; lat = -1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk); #1;
         if (rsp_valid_o) begin seen = 1'b1; lat = cyc - ta; end
      end
      check("t1_latency", 64'(lat), 64'd3);
      wait_drain();

      // Read with grant delayed three cycles: request held for four cycles
      gnt_delay = 3;
      send(1'b0, 32'h10, 32'h0, 4'hF, 32'h0000_00FF, 1'b0, 0);
      cmd_idle();
      nreq = 0; seen = 1'b0;
      for (int k = 0; k < 30 && !seen; k++) begin
         @(negedge clk); #1;
         if (obi_req_o) nreq++;
         if (rsp_valid_o) seen = 1'b1;
      end
      check("t2_req_cycles", 64'(nreq), 64'd4);
      wait_drain();
      gnt_delay = 0;

      // Six back-to-back reads with responses blocked: credit limit stops at four
      rdy = 1'b0;
      base = n_gnt;
      fork
         begin
            for (int i = 0; i < 6; i++) send(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF, 32'h3000_0000 + 32'(i), 1'b0, 0);
            cmd_idle();
         end
      join_none
      repeat (20) @(negedge clk);
      #1;
      check("t3_grants_capped", 64'(n_gnt - base), 64'd4);
      check("t3_req_low", {63'h0, obi_req_o}, 64'h0);
      check("t3_busy", {63'h0, busy_o}, 64'h1);
      @(posedge clk); #1;
      rdy = 1'b1;
      wait_drain();
      check("t3_grants_all", 64'(n_gnt - base), 64'd6);

      // Local range error between two reads keeps response order
      base = n_gnt;
      send(1'b0, 32'h20, 32'h0, 4'hF, 32'h1111_2222, 1'b0, 5);
      send(1'b0, 32'h2000, 32'h0, 4'hF, 32'h0, 1'b0, 0);
      send(1'b0, 32'h24, 32'h0, 4'hF, 32'h3333_4444, 1'b0, 0);
      cmd_idle();
      wait_drain();
      check("t4_grants", 64'(n_gnt - base), 64'd2);

      // Bus error on a write
      send(1'b1, 32'h8, 32'hDEAD_BEEF, 4'h3, 32'h0, 1'b1, 0);
      cmd_idle();
      wait_drain();

      // Reset with two transactions outstanding; their responses arrive during reset
      base = n_gnt;
      send(1'b0, 32'h30, 32'h0, 4'hF, 32'h5555_0001, 1'b0, 6);
      send(1'b0, 32'h34, 32'h0, 4'hF, 32'h5555_0002, 1'b0, 6);
      cmd_idle();
      for (int k = 0; k < 20 && (n_gnt - base) < 2; k++) begin
         @(negedge clk); #1;
      end
      check("t6_outstanding", 64'(n_gnt - base), 64'd2);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("t6_rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h0);
      check("t6_rst_req", {63'h0, obi_req_o}, 64'h0);
      check("t6_rst_addr", {32'h0, obi_addr_o}, 64'h0);
      check("t6_rst_we", {63'h0, obi_we_o}, 64'h0);
      check("t6_rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
      check("t6_rst_rdata", {32'h0, rsp_rdata_o}, 64'h0);
      check("t6_rst_busy", {63'h0, busy_o}, 64'h0);
      exp_q.delete();
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         check("t6_post_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
         check("t6_post_busy", {63'h0, busy_o}, 64'h0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
